// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters, with read-return tracking.
// Optional feature macro: ARB_ACCESS_COUNT_EN adds saturating per-port accepted-transfer counters.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
);

  logic              gnt0_s;
  logic              gnt1_s;
  logic              accepted_s;
  logic              last_q;
  logic              last_d;
  logic [RD_LAT-1:0] pipe_valid_q;
  logic [RD_LAT-1:0] pipe_valid_d;
  logic [RD_LAT-1:0] pipe_owner_q;
  logic [RD_LAT-1:0] pipe_owner_d;

  // Grant: on a tie the port that was not served most recently wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case ({req1, req0})
        2'b01:   gnt0_s = 1'b1;
        2'b10:   gnt1_s = 1'b1;
        2'b11: begin
          if (last_q) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  assign accepted_s = gnt0_s | gnt1_s;
  assign gnt0       = gnt0_s;
  assign gnt1       = gnt1_s;

  // RAM port steering; port 0 drives address/data when idle.
  always_comb begin
    ram_address = addr0;
    ram_data    = wdata0;
    ram_wren    = 1'b0;
    if (gnt1_s) begin
      ram_address = addr1;
      ram_data    = wdata1;
      ram_wren    = we1;
    end else if (gnt0_s) begin
      ram_wren    = we0;
    end else begin
      ram_wren    = 1'b0;
    end
  end

  always_comb begin
    last_d       = last_q;
    pipe_valid_d = pipe_valid_q;
    pipe_owner_d = pipe_owner_q;
    if (accepted_s) begin
      last_d = gnt1_s;
    end else begin
      last_d = last_q;
    end
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_owner_d[i] = pipe_owner_q[i-1];
    end
    // Writes enter the pipe as bubbles so only reads produce a return pulse.
    pipe_valid_d[0] = accepted_s & ~ram_wren;
    pipe_owner_d[0] = gnt1_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q       <= 1'b1;
      pipe_valid_q <= '0;
      pipe_owner_q <= '0;
    end else begin
      last_q       <= last_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_owner_q <= pipe_owner_d;
    end
  end

  assign rvalid0 = pipe_valid_q[RD_LAT-1] & ~pipe_owner_q[RD_LAT-1];
  assign rvalid1 = pipe_valid_q[RD_LAT-1] &  pipe_owner_q[RD_LAT-1];
  assign rdata0  = ram_q;
  assign rdata1  = ram_q;

`ifdef ARB_ACCESS_COUNT_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt0_d;
  logic [15:0] cnt1_q;
  logic [15:0] cnt1_d;

  // Accepted-transfer counters, saturating at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0_s && (cnt0_q != 16'hFFFF)) begin
      cnt0_d = cnt0_q + 16'd1;
    end else begin
      cnt0_d = cnt0_q;
    end
    if (gnt1_s && (cnt1_q != 16'hFFFF)) begin
      cnt1_d = cnt1_q + 16'd1;
    end else begin
      cnt1_d = cnt1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = 16'd0;
  assign cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 256x8 RAM (one-edge read latency).
module tb_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_wren;
  logic [7:0]  rdata0, rdata1, ram_address, ram_data, ram_q;
  logic [15:0] cnt0, cnt1;
  logic [7:0]  mem [0:255];
  int          checks;
  int          errors;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit before driving new inputs.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[1] = 8'hA1;
    mem[2] = 8'hB2;
    ram_q = 8'h00;
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h00; wdata1 = 8'h00;
    #3;
    check_eq("rst_gnt0", gnt0, 1'b0);
    check_eq("rst_gnt1", gnt1, 1'b0);
    check_eq("rst_wren", ram_wren, 1'b0);
    check_eq("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
    check_eq("rst_cnt", {cnt1, cnt0}, 32'h0);
    tick(); tick();
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b0;

    // Write 123 to 0x10 from port 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'd123;
    #4;
    check_eq("wr_gnt", {gnt1, gnt0}, 2'b01);
    check_eq("wr_wren", ram_wren, 1'b1);
    check_eq("wr_addr", ram_address, 8'h10);
    check_eq("wr_data", ram_data, 8'd123);
    tick();
    // Read 0x10 from port 1
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    #4;
    check_eq("rd_gnt", {gnt1, gnt0}, 2'b10);
    check_eq("rd_wren", ram_wren, 1'b0);
    check_eq("rd_addr", ram_address, 8'h10);
    check_eq("wr_no_rvalid", {rvalid1, rvalid0}, 2'b00);
    tick();
    req1 = 1'b0;
    #4;
    check_eq("raw_rvalid", {rvalid1, rvalid0}, 2'b10);
    check_eq("raw_rdata1", rdata1, 8'd123);
    tick();
    check_eq("idle_rvalid", {rvalid1, rvalid0}, 2'b00);

    // Contention: port 0 reads 0x01, port 1 reads 0x02; last=1 so 0 first
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    for (int k = 0; k < 6; k++) begin
      #4;
      check_eq("alt_gnt", {gnt1, gnt0}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        check_eq("alt_rvalid", {rvalid1, rvalid0}, (k % 2 == 0) ? 2'b10 : 2'b01);
        check_eq("alt_rdata", rdata0, (k % 2 == 0) ? 8'hB2 : 8'hA1);
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    #4;
    check_eq("alt_last_rvalid", {rvalid1, rvalid0}, 2'b10);
    check_eq("alt_last_rdata1", rdata1, 8'hB2);
    tick();

    // Port 1 alone writes 0x21,0x22,0x23 to 0x03, then a tie goes to port 0
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h03;
    for (int k = 0; k < 3; k++) begin
      wdata1 = 8'h21 + 8'(k);
      #4;
      check_eq("solo1_gnt", {gnt1, gnt0}, 2'b10);
      check_eq("solo1_wren", ram_wren, 1'b1);
      check_eq("solo1_data", ram_data, 8'h21 + 8'(k));
      tick();
    end
    wdata1 = 8'h24;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h03;
    #4;
    check_eq("tie_gnt", {gnt1, gnt0}, 2'b01);
    check_eq("tie_addr", ram_address, 8'h03);
    tick();
    req0 = 1'b0;
    #4;
    check_eq("tie_next_gnt", {gnt1, gnt0}, 2'b10);
    check_eq("tie_rvalid", {rvalid1, rvalid0}, 2'b01);
    check_eq("tie_rdata0", rdata0, 8'h23);
    tick();
    req1 = 1'b0;

    // Reset in the cycle after a read acceptance drops the pending return
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    #4;
    check_eq("pre_rst_gnt", {gnt1, gnt0}, 2'b01);
    tick();
    req0 = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("midrst_rvalid", {rvalid1, rvalid0}, 2'b00);
    check_eq("midrst_cnt", {cnt1, cnt0}, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("post_rst_rvalid", {rvalid1, rvalid0}, 2'b00);

    // Counted run: ties alternate 0,1,0,1,0 then port 0 twice, port 1 once
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h55;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h41; wdata1 = 8'h66;
    #3;
    check_eq("post_rst_tie", {gnt1, gnt0}, 2'b01);
    for (int k = 0; k < 5; k++) tick();
    req1 = 1'b0;
    tick(); tick();
    req0 = 1'b0; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    #4;
`ifdef ARB_ACCESS_COUNT_EN
    check_eq("cnt0", cnt0, 16'd5);
    check_eq("cnt1", cnt1, 16'd3);
`else
    check_eq("cnt0", cnt0, 16'd0);
    check_eq("cnt1", cnt1, 16'd0);
`endif
    check_eq("end_idle_gnt", {gnt1, gnt0}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Round-robin arbiter that shares the single-port 256x8 RAM (ram1) between two requesters.
- Each cycle it grants at most one request and steers that requester's address, data and write-enable onto the RAM port.
- It tracks in-flight reads so read data is returned to the port that issued the read.
- It sits between the switch/debug front end and a second agent (e.g. a fill or scan engine), directly in front of ram1.

Parameters:
ADDR_W, 8, address width (RAM depth 2^ADDR_W)
DATA_W, 8, data width
RD_LAT, 1, RAM read latency in clock edges from acceptance edge to valid ram_q (1..4)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  port 0 request; held until accepted
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 grant (combinational); transfer occurs on edge where req0&gnt0
rvalid0  out  1  port 0 read data valid, 1-cycle pulse
rdata0  out  DATA_W  port 0 read data, meaningful only when rvalid0
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
ram_address  out  ADDR_W  to ram1 address
ram_data  out  DATA_W  to ram1 data
ram_wren  out  1  to ram1 wren
ram_q  in  DATA_W  from ram1 out

Behaviour:
- Priority pointer `last` (1 bit, registered) holds the port granted most recently. Reset value: last=1, so port 0 wins the first tie.
- Grant logic is combinational:
  - only req0 -> gnt0
  - only req1 -> gnt1
  - both requests -> grant the port != last
  - no request -> no grant
  - gnt0 and gnt1 are never both 1.
  - During reset, gnt0=gnt1=0.
- On an edge with an accepted transfer, `last` updates to the granted port. Otherwise `last` holds.
- RAM-side mux (combinational):
  - ram_address/ram_data come from the granted port; from port 0 when idle.
  - ram_wren = accepted & granted we. It is 0 when idle and 0 during reset.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed when the other port is idle.
- Read tracking uses a shift pipe of RD_LAT stages, each stage {valid, owner}.
  - An accepted read enters stage 0 with owner = granted port.
  - Writes insert valid=0.
  - rvalidN = last-stage valid & owner==N. This pulses exactly RD_LAT cycles after the acceptance edge; with RD_LAT=1, it pulses in the cycle following acceptance.
  - rdata0 = rdata1 = ram_q (pass-through).
- Read after write to the same address, next cycle: returns the newly written data. Single port means no same-cycle read/write conflict is possible.
- Requester holding req without a grant: no state change for that port; its request persists across cycles.
- Reset, including mid-operation:
  - all pipe stages clear, so pending rvalids are dropped and not replayed
  - last=1
  - rvalid0=rvalid1=0, gnt0=gnt1=0, ram_wren=0
- Request changes while waiting: addr/we/wdata may change while req is high and ungranted. Only values present on the accepting edge are used.

Optional Feature:
ARB_ACCESS_COUNT_EN
- Defined:
  - Adds outputs cnt0, cnt1 (16 bits each). Each counts accepted transfers for its port.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined:
  - cnt0/cnt1 ports remain and are driven to constant 0.
  - No counter registers are synthesized.

Test Plan:
- Reset, then req0=1, we0=1, addr0=8'h10, wdata0=8'd123 for one cycle -> gnt0=1 that cycle, ram_wren=1, ram_address=8'h10; rvalid0 stays 0.
- Next cycle, req1=1, we1=0, addr1=8'h10 -> gnt1=1; rvalid1=1 with rdata1=8'd123 one cycle later (RD_LAT=1); rvalid0 stays 0.
- req0 and req1 both held high for 6 cycles, reads to 8'h01/8'h02 -> grants alternate 0,1,0,1,0,1; each rvalid pulse goes to the port that issued the matching read.
- req1 alone for 3 cycles, then both requesters -> after three port-1 grants, the tie goes to port 0.
- Reset asserted in the cycle after a read acceptance -> no rvalid pulse; after release, last=1 and a tie grants port 0.
- ARB_ACCESS_COUNT_EN defined: 5 port-0 and 3 port-1 accepted transfers -> cnt0=5, cnt1=3. Macro undefined -> cnt0=cnt1=0.
